// File: rtl/alu32_mdu_seq_if.sv
// Request/response bus between an issuing initiator and the alu32_mdu_seq responder.
// The initiator uses the master modport; the multiply/divide unit uses the slave modport.
interface alu32_mdu_seq_if #(
    parameter int XLEN = 32,
    parameter int CTLW = 24
);
    logic            in_vld;
    logic            in_rdy;
    logic [CTLW-1:0] ctl;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            out_vld;
    logic            out_rdy;
    logic [XLEN-1:0] res;
    logic            err;

    modport master (
        output in_vld, ctl, op1, op2, out_rdy,
        input  in_rdy, out_vld, res, err
    );

    modport slave (
        input  in_vld, ctl, op1, op2, out_rdy,
        output in_rdy, out_vld, res, err
    );
endinterface

// File: rtl/alu32_mdu_seq.sv
// Iterative multiply/divide unit: 32-cycle shift-add multiply and restoring divide.
// Optional macro ALU32_MDU_EARLY_OUT_EN lets trivial cases (x/0, overflow, x*0) skip the iterations.
`ifndef ALU_CTL_MUL
`define ALU_CTL_MUL  24'h000001
`endif
`ifndef ALU_CTL_MULH
`define ALU_CTL_MULH 24'h000002
`endif
`ifndef ALU_CTL_DIV
`define ALU_CTL_DIV  24'h000004
`endif
`ifndef ALU_CTL_DIVU
`define ALU_CTL_DIVU 24'h000008
`endif
`ifndef ALU_CTL_REM
`define ALU_CTL_REM  24'h000010
`endif
`ifndef ALU_CTL_REMU
`define ALU_CTL_REMU 24'h000020
`endif

module alu32_mdu_seq #(
    parameter int XLEN = 32,
    parameter int CTLW = 24
) (
    input  logic            clk,
    input  logic            rst_n,
    alu32_mdu_seq_if.slave  bus
);
    localparam logic [CTLW-1:0] CTL_MUL  = `ALU_CTL_MUL;
    localparam logic [CTLW-1:0] CTL_MULH = `ALU_CTL_MULH;
    localparam logic [CTLW-1:0] CTL_DIV  = `ALU_CTL_DIV;
    localparam logic [CTLW-1:0] CTL_DIVU = `ALU_CTL_DIVU;
    localparam logic [CTLW-1:0] CTL_REM  = `ALU_CTL_REM;
    localparam logic [CTLW-1:0] CTL_REMU = `ALU_CTL_REMU;
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
`ifdef ALU32_MDU_EARLY_OUT_EN
    localparam logic EARLY_OUT = 1'b1;
`else
    localparam logic EARLY_OUT = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_wide(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [XLEN-1:0] neg_narrow(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    state_t state, state_n;
    logic [4:0]        cnt;
    logic [CTLW-1:0]   ctl_q;
    logic [XLEN-1:0]   a_q, b_q;
    logic [XLEN:0]     hi;
    logic [XLEN-1:0]   lo, mc;
    logic              neg_q, err_q, spec_q, err_out;
    logic [XLEN-1:0]   spec_val_q, res_q;

    logic is_mul, is_mulh, is_div, is_divu, is_rem, is_remu;
    logic op_mul, op_div, sgn, supported, sa, sb;
    logic div0, ovf, mzero, spec_hit;
    logic [XLEN-1:0]   spec_val_d;
    logic [XLEN:0]     mul_sum, div_shift;
    logic [XLEN+1:0]   div_diff;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rmd, fix_res;

    always_comb begin
        is_mul    = (ctl_q == CTL_MUL);
        is_mulh   = (ctl_q == CTL_MULH);
        is_div    = (ctl_q == CTL_DIV);
        is_divu   = (ctl_q == CTL_DIVU);
        is_rem    = (ctl_q == CTL_REM);
        is_remu   = (ctl_q == CTL_REMU);
        op_mul    = is_mul | is_mulh;
        op_div    = is_div | is_divu | is_rem | is_remu;
        sgn       = is_mulh | is_div | is_rem;
        supported = op_mul | op_div;
        sa        = sgn & a_q[XLEN-1];
        sb        = sgn & b_q[XLEN-1];
        div0      = op_div && (b_q == '0);
        ovf       = (is_div | is_rem) && (a_q == MIN_NEG) && (b_q == '1);
        mzero     = op_mul && ((a_q == '0) || (b_q == '0));
        spec_hit  = div0 | ovf | mzero;
        // Divide by zero returns all-ones quotient / untouched dividend, never a signed fix-up.
        spec_val_d = '0;
        if (div0)
            spec_val_d = (is_div | is_divu) ? '1 : a_q;
        else if (ovf)
            spec_val_d = is_div ? MIN_NEG : '0;
    end

    always_comb begin
        mul_sum   = hi + {1'b0, (lo[0] ? mc : '0)};
        div_shift = {hi[XLEN-1:0], lo[XLEN-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, mc};
        prod      = neg_wide({hi[XLEN-1:0], lo}, neg_q);
        quo       = neg_narrow(lo, neg_q);
        rmd       = neg_narrow(hi[XLEN-1:0], neg_q);
        if (err_q)
            fix_res = '0;
        else if (spec_q)
            fix_res = spec_val_q;
        else if (is_mul)
            fix_res = prod[XLEN-1:0];
        else if (is_mulh)
            fix_res = prod[2*XLEN-1:XLEN];
        else if (is_div | is_divu)
            fix_res = quo;
        else
            fix_res = rmd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    // Short paths still pass through FIX so the result is selected in one place (2-cycle latency).
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (bus.in_vld) state_n = S_PREP;
            S_PREP: state_n = (!supported || (EARLY_OUT && spec_hit)) ? S_FIX : S_CALC;
            S_CALC: if (cnt == 5'(XLEN-1)) state_n = S_FIX;
            S_FIX:  state_n = S_DONE;
            S_DONE: if (bus.out_rdy) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            ctl_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            hi         <= '0;
            lo         <= '0;
            mc         <= '0;
            neg_q      <= 1'b0;
            err_q      <= 1'b0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
            res_q      <= '0;
            err_out    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_vld) begin
                        ctl_q <= bus.ctl;
                        a_q   <= bus.op1;
                        b_q   <= bus.op2;
                    end
                end
                S_PREP: begin
                    cnt        <= '0;
                    hi         <= '0;
                    neg_q      <= (is_mulh | is_div) ? (sa ^ sb) : (is_rem ? sa : 1'b0);
                    err_q      <= ~supported;
                    spec_q     <= spec_hit;
                    spec_val_q <= spec_val_d;
                    // Multiply shifts the multiplier through lo; divide shifts the dividend.
                    lo <= op_mul ? abs_val(b_q, sgn) : abs_val(a_q, sgn);
                    mc <= op_mul ? abs_val(a_q, sgn) : abs_val(b_q, sgn);
                end
                S_CALC: begin
                    cnt <= cnt + 5'd1;
                    if (op_mul) begin
                        hi <= {1'b0, mul_sum[XLEN:1]};
                        lo <= {mul_sum[0], lo[XLEN-1:1]};
                    end else begin
                        hi <= div_diff[XLEN+1] ? div_shift : div_diff[XLEN:0];
                        lo <= {lo[XLEN-2:0], ~div_diff[XLEN+1]};
                    end
                end
                S_FIX: begin
                    res_q   <= fix_res;
                    err_out <= err_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_rdy  = (state == S_IDLE);
    assign bus.out_vld = (state == S_DONE);
    assign bus.res     = res_q;
    assign bus.err     = err_out;

endmodule

// File: tb/tb_alu32_mdu_seq.sv
// Directed-vector bench for alu32_mdu_seq: results, latency, backpressure and reset abort.
`ifndef ALU_CTL_MUL
`define ALU_CTL_MUL  24'h000001
`endif
`ifndef ALU_CTL_MULH
`define ALU_CTL_MULH 24'h000002
`endif
`ifndef ALU_CTL_DIV
`define ALU_CTL_DIV  24'h000004
`endif
`ifndef ALU_CTL_DIVU
`define ALU_CTL_DIVU 24'h000008
`endif
`ifndef ALU_CTL_REM
`define ALU_CTL_REM  24'h000010
`endif
`ifndef ALU_CTL_REMU
`define ALU_CTL_REMU 24'h000020
`endif

module tb_alu32_mdu_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

`ifdef ALU32_MDU_EARLY_OUT_EN
    localparam int SPEC_LAT = 2;
`else
    localparam int SPEC_LAT = 34;
`endif

    alu32_mdu_seq_if #(.XLEN(32), .CTLW(24)) bus ();

    alu32_mdu_seq #(.XLEN(32), .CTLW(24)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Issue one request, wait for its result, then complete the handshake.
    task automatic do_op(input logic [23:0] c, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic e, output int lat, output bit rdy_low);
        int n;
        n = 0;
        while (!bus.in_rdy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        bus.in_vld = 1'b1;
        bus.ctl = c;
        bus.op1 = a;
        bus.op2 = b;
        @(posedge clk); #1;
        bus.in_vld = 1'b0;
        bus.ctl = 24'hFFFFFF;
        bus.op1 = ~a;
        bus.op2 = ~b;
        lat = 0;
        rdy_low = 1'b1;
        while (!bus.out_vld && lat < 200) begin
            if (bus.in_rdy) rdy_low = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        r = bus.res;
        e = bus.err;
        bus.out_rdy = 1'b1;
        @(posedge clk); #1;
        bus.out_rdy = 1'b0;
    endtask

    task automatic check_op(input string name, input logic [23:0] c, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_res, input logic exp_err,
                            input int exp_lat);
        logic [31:0] r;
        logic e;
        int lat;
        bit rdy_low;
        do_op(c, a, b, r, e, lat, rdy_low);
        checks++;
        if (r !== exp_res) begin
            failures++;
            $display("FAIL %s res: got %h required %h", name, r, exp_res);
        end
        checks++;
        if (e !== exp_err) begin
            failures++;
            $display("FAIL %s err: got %b required %b", name, e, exp_err);
        end
        checks++;
        if (lat != exp_lat) begin
            failures++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
        end
        checks++;
        if (!rdy_low) begin
            failures++;
            $display("FAIL %s in_rdy busy: got 1 required 0", name);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (bus.in_rdy !== 1'b1 || bus.out_vld !== 1'b0 || bus.res !== 32'h0 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got rdy=%b vld=%b res=%h err=%b required 1 0 0 0",
                     bus.in_rdy, bus.out_vld, bus.res, bus.err);
        end
    endtask

    task automatic test_mul();
        check_op("mul", `ALU_CTL_MUL, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 34);
        check_op("mulh_min", `ALU_CTL_MULH, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 34);
        check_op("mulh_neg", `ALU_CTL_MULH, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0, 34);
    endtask

    task automatic test_div();
        check_op("div",  `ALU_CTL_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, 34);
        check_op("rem",  `ALU_CTL_REM,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0, 34);
        check_op("divu", `ALU_CTL_DIVU, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 1'b0, 34);
        check_op("remu", `ALU_CTL_REMU, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 1'b0, 34);
    endtask

    task automatic test_special();
        check_op("divu_by0", `ALU_CTL_DIVU, 32'h12345678, 32'h0, 32'hFFFFFFFF, 1'b0, SPEC_LAT);
        check_op("rem_by0",  `ALU_CTL_REM,  32'h12345678, 32'h0, 32'h12345678, 1'b0, SPEC_LAT);
        check_op("div_by0_neg", `ALU_CTL_DIV, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFFF, 1'b0, SPEC_LAT);
        check_op("div_ovf",  `ALU_CTL_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, SPEC_LAT);
        check_op("rem_ovf",  `ALU_CTL_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, SPEC_LAT);
        check_op("mul_nz",   `ALU_CTL_MUL,  32'h00000003, 32'h00000004, 32'h0000000C, 1'b0, 34);
        check_op("mul_zero", `ALU_CTL_MUL,  32'h00000000, 32'h12345678, 32'h00000000, 1'b0, SPEC_LAT);
    endtask

    task automatic test_back_to_back();
        int lat;
        bus.in_vld = 1'b1;
        bus.ctl = `ALU_CTL_MUL;
        bus.op1 = 32'd3;
        bus.op2 = 32'd5;
        @(posedge clk); #1;
        bus.in_vld = 1'b0;
        lat = 0;
        while (!bus.out_vld && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != 34 || bus.res !== 32'd15) begin
            failures++;
            $display("FAIL bp_first: got lat=%0d res=%h required 34 0000000f", lat, bus.res);
        end
        bus.in_vld = 1'b1;
        bus.ctl = `ALU_CTL_DIVU;
        bus.op1 = 32'd100;
        bus.op2 = 32'd9;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.out_vld !== 1'b1 || bus.res !== 32'd15 || bus.in_rdy !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d: got vld=%b res=%h rdy=%b required 1 0000000f 0",
                         i, bus.out_vld, bus.res, bus.in_rdy);
            end
        end
        bus.out_rdy = 1'b1;
        @(posedge clk); #1;
        bus.out_rdy = 1'b0;
        checks++;
        if (bus.out_vld !== 1'b0 || bus.in_rdy !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: got vld=%b rdy=%b required 0 1", bus.out_vld, bus.in_rdy);
        end
        @(posedge clk); #1;
        bus.in_vld = 1'b0;
        checks++;
        if (bus.in_rdy !== 1'b0) begin
            failures++;
            $display("FAIL bp_second_accept: got rdy=%b required 0", bus.in_rdy);
        end
        lat = 0;
        while (!bus.out_vld && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != 34 || bus.res !== 32'd11 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL bp_second: got lat=%0d res=%h err=%b required 34 0000000b 0",
                     lat, bus.res, bus.err);
        end
        bus.out_rdy = 1'b1;
        @(posedge clk); #1;
        bus.out_rdy = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.in_vld = 1'b1;
        bus.ctl = `ALU_CTL_DIV;
        bus.op1 = 32'h00001000;
        bus.op2 = 32'h00000003;
        @(posedge clk); #1;
        bus.in_vld = 1'b0;
        repeat (15) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_vld !== 1'b0 || bus.in_rdy !== 1'b1 || bus.res !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid: got vld=%b rdy=%b res=%h required 0 1 00000000",
                     bus.out_vld, bus.in_rdy, bus.res);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_op("after_reset", `ALU_CTL_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 34);
        check_op("unsupported", 24'h000000, 32'h11111111, 32'h22222222, 32'h0, 1'b1, 2);
    endtask

    initial begin
        bus.in_vld = 1'b0;
        bus.ctl = '0;
        bus.op1 = '0;
        bus.op2 = '0;
        bus.out_rdy = 1'b0;
        #12;
        test_reset();
        #5;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_mul();
        test_div();
        test_special();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
